// File: rtl/monitor_pkg.sv
// Shared types and helpers for the monitor scheduler.
// States, default count width and a popcount helper used by the optional MON_CHECK_EN shadow check.
package monitor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        SETTLE = 2'd2
    } state_e;

    localparam int CNT_W_DEF = 8;
    localparam int N_DEV_MAX = 16;

    function automatic logic [4:0] popcount(input logic [N_DEV_MAX-1:0] v);
        logic [4:0] cnt;
        cnt = '0;
        for (int i = 0; i < N_DEV_MAX; i++) begin
            cnt = cnt + {4'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requester at or after ptr, wrapping from N_DEV-1 to 0.
module rr_arbiter #(
    parameter int N_DEV = 4,
    parameter int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1
) (
    input  logic [N_DEV-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_DEV-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int unsigned cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = 0;
        for (int i = 0; i < N_DEV; i++) begin
            cand = (int'(ptr) + i) % N_DEV;
            if (!valid && req[IDX_W'(cand)]) begin
                valid                = 1'b1;
                grant[IDX_W'(cand)]  = 1'b1;
                idx                  = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/monitor_scheduler.sv
// Round-robin scheduler sharing one active-device monitor counter between N_DEV requesters.
// Define MON_CHECK_EN to compare a shadow popcount of active_map against mon_count (sticky err).
//
// state  | meaning
// IDLE   | waiting for any dev_req; arbitrate and latch winner
// ISSUE  | dev_ack / mon_change pulse for the latched winner
// SETTLE | monitor register updates, device drops its request
module monitor_scheduler
    import monitor_pkg::*;
#(
    parameter int N_DEV = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_DEV-1:0] dev_req,
    input  logic [N_DEV-1:0] dev_on,
    output logic [N_DEV-1:0] dev_ack,
    output logic             mon_change,
    output logic             mon_on_off,
    input  logic [CNT_W-1:0] mon_count,
    output logic [N_DEV-1:0] active_map,
    output logic             busy,
    output logic             err
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic             on_q, on_d;
    logic [N_DEV-1:0] active_q, active_d;
    logic [N_DEV-1:0] ack_q, ack_d;
    logic             chg_q, chg_d;
    logic             onoff_q, onoff_d;

    logic [N_DEV-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_valid;

    rr_arbiter #(
        .N_DEV (N_DEV),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (dev_req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        on_d     = on_q;
        active_d = active_q;
        ack_d    = '0;
        chg_d    = 1'b0;
        onoff_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    win_d   = arb_idx;
                    on_d    = dev_on[arb_idx];
                    // Pulses are registered so they appear exactly during ISSUE.
                    ack_d   = arb_grant;
                    chg_d   = dev_on[arb_idx] != active_q[arb_idx];
                    onoff_d = chg_d & dev_on[arb_idx];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (chg_q) begin
                    active_d[win_q] = on_q;
                end
                ptr_d   = (win_q == IDX_W'(N_DEV - 1)) ? '0 : win_q + IDX_W'(1);
                state_d = SETTLE;
            end
            SETTLE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            on_q     <= 1'b0;
            active_q <= '0;
            ack_q    <= '0;
            chg_q    <= 1'b0;
            onoff_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            on_q     <= on_d;
            active_q <= active_d;
            ack_q    <= ack_d;
            chg_q    <= chg_d;
            onoff_q  <= onoff_d;
        end
    end

    assign dev_ack    = ack_q;
    assign mon_change = chg_q;
    assign mon_on_off = onoff_q;
    assign active_map = active_q;
    assign busy       = (state_q != IDLE);

`ifdef MON_CHECK_EN
    logic             issued_q, issued_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] shadow_cnt;

    // Monitor has absorbed the ISSUE pulse by SETTLE, so err is visible in the first IDLE cycle.
    always_comb begin
        shadow_cnt = CNT_W'(popcount(N_DEV_MAX'(active_q)));
        issued_d   = (state_q == ISSUE) ? chg_q : 1'b0;
        err_d      = err_q;
        if (state_q == SETTLE && issued_q && shadow_cnt != mon_count) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            issued_q <= issued_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_mon_count;
    assign unused_mon_count = ^mon_count;
    assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_monitor_scheduler.sv
// Directed self-checking bench for monitor_scheduler with a behavioural monitor counter.
module tb_monitor_scheduler;

    localparam int N_DEV = 4;
    localparam int CNT_W = 8;
`ifdef MON_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic [N_DEV-1:0] dev_req;
    logic [N_DEV-1:0] dev_on;
    logic [N_DEV-1:0] dev_ack;
    logic             mon_change;
    logic             mon_on_off;
    logic [CNT_W-1:0] mon_count;
    logic [N_DEV-1:0] active_map;
    logic             busy;
    logic             err;

    logic [CNT_W-1:0] mon_cnt;
    logic             force_zero;

    int n_checks;
    int n_fail;

    monitor_scheduler #(
        .N_DEV (N_DEV),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dev_req    (dev_req),
        .dev_on     (dev_on),
        .dev_ack    (dev_ack),
        .mon_change (mon_change),
        .mon_on_off (mon_on_off),
        .mon_count  (mon_count),
        .active_map (active_map),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Behavioural Active IoT Devices Monitor counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mon_cnt <= '0;
        end else if (mon_change) begin
            mon_cnt <= mon_on_off ? mon_cnt + 8'd1 : mon_cnt - 8'd1;
        end
    end

    assign mon_count = force_zero ? '0 : mon_cnt;

    task automatic test_reset;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dev_ack, mon_change, mon_on_off, busy, err} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b chg=%b onoff=%b busy=%b err=%b, want all 0",
                     dev_ack, mon_change, mon_on_off, busy, err);
        end
        n_checks++;
        if (active_map !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_active_map: got %b want 0000", active_map);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_on;
        dev_req = 4'b0001;
        dev_on  = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (dev_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ack: got %b want 0001", dev_ack);
        end
        n_checks++;
        if ({mon_change, mon_on_off, busy} !== 3'b111) begin
            n_fail++;
            $display("FAIL single_pulse: got chg=%b onoff=%b busy=%b want 1 1 1", mon_change, mon_on_off, busy);
        end
        dev_req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if ({dev_ack, mon_change} !== 5'b0) begin
            n_fail++;
            $display("FAIL single_settle_quiet: got ack=%b chg=%b want 0", dev_ack, mon_change);
        end
        n_checks++;
        if (active_map !== 4'b0001 || mon_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_state: got map=%b cnt=%0d want 0001 1", active_map, mon_count);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_redundant;
        dev_req = 4'b0001;
        dev_on  = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (dev_ack !== 4'b0001 || mon_change !== 1'b0) begin
            n_fail++;
            $display("FAIL redundant_ack: got ack=%b chg=%b want 0001 0", dev_ack, mon_change);
        end
        dev_req = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (active_map !== 4'b0001 || mon_count !== 8'd1) begin
            n_fail++;
            $display("FAIL redundant_state: got map=%b cnt=%0d want 0001 1", active_map, mon_count);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        logic [N_DEV-1:0] exp_ack;
        int cycles;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        dev_req = 4'b1111;
        dev_on  = 4'b1111;
        for (int k = 0; k < N_DEV; k++) begin
            exp_ack = 4'b0001 << k;
            @(negedge clk);
            cycles = 1;
            while (dev_ack == 4'b0000 && cycles < 20) begin
                @(negedge clk);
                cycles++;
            end
            n_checks++;
            if (dev_ack !== exp_ack || mon_change !== 1'b1) begin
                n_fail++;
                $display("FAIL contention_grant%0d: got ack=%b chg=%b want %b 1", k, dev_ack, mon_change, exp_ack);
            end
            n_checks++;
            if (cycles != ((k == 0) ? 1 : 3)) begin
                n_fail++;
                $display("FAIL contention_gap%0d: got %0d cycles want %0d", k, cycles, (k == 0) ? 1 : 3);
            end
            dev_req[k] = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (active_map !== 4'b1111 || mon_count !== 8'd4) begin
            n_fail++;
            $display("FAIL contention_state: got map=%b cnt=%0d want 1111 4", active_map, mon_count);
        end
    endtask

    task automatic test_wrap;
        int cycles;
        // Turning device 2 off leaves the pointer at 3.
        dev_req = 4'b0100;
        dev_on  = 4'b0000;
        @(negedge clk);
        n_checks++;
        if (dev_ack !== 4'b0100 || mon_change !== 1'b1 || mon_on_off !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_setup: got ack=%b chg=%b onoff=%b want 0100 1 0", dev_ack, mon_change, mon_on_off);
        end
        dev_req = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        dev_req = 4'b1001;
        @(negedge clk);
        cycles = 1;
        while (dev_ack == 4'b0000 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (dev_ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got ack=%b want 1000", dev_ack);
        end
        dev_req[3] = 1'b0;
        @(negedge clk);
        cycles = 1;
        while (dev_ack == 4'b0000 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        n_checks++;
        if (dev_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_second: got ack=%b want 0001", dev_ack);
        end
        dev_req[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (active_map !== 4'b0010 || mon_count !== 8'd1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_state: got map=%b cnt=%0d err=%b want 0010 1 0", active_map, mon_count, err);
        end
    endtask

    task automatic test_reset_mid_issue;
        dev_req = 4'b0001;
        dev_on  = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (mon_change !== 1'b1 || dev_ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL midreset_pre: got chg=%b ack=%b want 1 0001", mon_change, dev_ack);
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if ({dev_ack, mon_change, mon_on_off, busy} !== 7'b0) begin
            n_fail++;
            $display("FAIL midreset_cut: got ack=%b chg=%b onoff=%b busy=%b want all 0",
                     dev_ack, mon_change, mon_on_off, busy);
        end
        n_checks++;
        if (active_map !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_map: got %b want 0000", active_map);
        end
        dev_req = 4'b0000;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dev_ack !== 4'b0000 || mon_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_idle: got busy=%b ack=%b cnt=%0d want 0 0000 0", busy, dev_ack, mon_count);
        end
    endtask

    task automatic test_mon_check;
        dev_req = 4'b0010;
        dev_on  = 4'b0010;
        @(negedge clk);
        dev_req    = 4'b0000;
        force_zero = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL check_early: got err=%b in SETTLE want 0", err);
        end
        @(negedge clk);
        n_checks++;
        if (err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL check_flag: got err=%b want %b", err, ERR_EXP);
        end
        force_zero = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++;
        if (err !== ERR_EXP) begin
            n_fail++;
            $display("FAIL check_sticky: got err=%b want %b", err, ERR_EXP);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL check_clear: got err=%b want 0", err);
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b0;
        dev_req    = '0;
        dev_on     = '0;
        force_zero = 1'b0;
        n_checks   = 0;
        n_fail     = 0;
        @(negedge clk);
        test_reset;
        test_single_on;
        test_redundant;
        test_back_to_back;
        test_wrap;
        test_reset_mid_issue;
        test_mon_check;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
